// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, FSM states
// and the ALU/PC mux select codes.
`timescale 1ns/1ps
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BRIMM = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_latency_counter.sv
// Cycle counter for memory states: cleared on state entry, done_o on the
// MEM_LAT-th cycle so the FSM leaves the memory state exactly then.
`timescale 1ns/1ps
module mips_latency_counter #(
  parameter int MEM_LAT = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign done_o = (cnt_q == CW'(MEM_LAT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && !done_o)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Moore control FSM for a multicycle MIPS datapath with retired-instruction
// counter. Define MIPS_CTRL_BNE_EN to add bne (opcode 000101) support.
`timescale 1ns/1ps
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [5:0]       Opcode,
  input  logic             Zero,
  output logic             PCEn,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             Mem2Reg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic             IllegalOp,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSrc,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] Retired
);

  state_e           state_q, state_d;
  logic             is_sw_q;
  logic [CNT_W-1:0] retired_q;
  logic             lat_done, lat_en, lat_clr, retire;

  assign lat_en  = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign lat_clr = (state_d != state_q);

  mips_latency_counter #(.MEM_LAT(MEM_LAT)) u_lat (
    .clk_i  (CLK),
    .rst_i  (RST),
    .clr_i  (lat_clr),
    .en_i   (lat_en),
    .done_o (lat_done)
  );

`ifdef MIPS_CTRL_BNE_EN
  logic is_bne_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                       is_bne_q <= 1'b0;
    else if (state_q == S_DECODE)  is_bne_q <= (Opcode == OP_BNE);
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_FETCH;
      is_sw_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) is_sw_q <= (Opcode == OP_SW);
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    PCEn      = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    Mem2Reg   = 1'b0;
    RegDst    = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    IllegalOp = 1'b0;
    ALUSrcB   = SRCB_REG;
    ALUOp     = ALUOP_ADD;
    PCSrc     = PCSRC_ALU;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = lat_done;
        PCEn    = lat_done;
        if (lat_done) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_BRIMM;
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            IllegalOp = 1'b1;
          end
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        if (state_q == S_ADDIEX) state_d = S_ADDIWB;
        else                     state_d = is_sw_q ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (lat_done) state_d = S_MEMWB;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (lat_done) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_MEMWB: begin
        Mem2Reg  = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB, S_ADDIWB: begin
        RegDst   = (state_q == S_ALUWB);
        RegWrite = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_SUB;
        PCSrc   = PCSRC_ALUOUT;
`ifdef MIPS_CTRL_BNE_EN
        PCEn    = is_bne_q ? ~Zero : Zero;
`else
        PCEn    = Zero;
`endif
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_JUMP: begin
        PCSrc   = PCSRC_JUMP;
        PCEn    = 1'b1;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset is asynchronous, so strobes must be squashed combinationally too.
    if (RST) begin
      PCEn     = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
    end
  end

  assign State   = state_q;
  assign Retired = retired_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench: per-instruction expected cycle sequences are queued by the
// driver and compared cycle by cycle by an independent monitor.
`timescale 1ns/1ps
module tb_mips_multicycle_control;

  localparam int L  = 3;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [5:0]    Opcode;
  logic          Zero;
  logic          PCEn, IorD, MemRead, MemWrite, IRWrite, Mem2Reg, RegDst, RegWrite, ALUSrcA, IllegalOp;
  logic [1:0]    ALUSrcB, ALUOp, PCSrc;
  logic [3:0]    State;
  logic [CW-1:0] Retired;

  mips_multicycle_control #(.MEM_LAT(L), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .Zero(Zero),
    .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .Mem2Reg(Mem2Reg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .IllegalOp(IllegalOp), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSrc(PCSrc), .State(State), .Retired(Retired)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0]    st;
    logic [15:0]   o;
    logic [CW-1:0] ret;
  } rec_t;

  rec_t q[$];
  rec_t mon_r;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  int   exp_ret = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] outs(input int st, input bit last, input bit z,
                                       input bit bne, input bit ill);
    logic pcen, iord, mr, mw, irw, m2r, rd, rw, sa, il;
    logic [1:0] sb, aop, pcs;
    {pcen, iord, mr, mw, irw, m2r, rd, rw, sa, il} = '0;
    sb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      0:    begin mr = 1; sb = 2'b01; irw = last; pcen = last; end
      1:    begin sb = 2'b11; il = ill; end
      2, 9: begin sa = 1; sb = 2'b10; end
      3:    begin iord = 1; mr = 1; end
      4:    begin m2r = 1; rw = 1; end
      5:    begin iord = 1; mw = 1; end
      6:    begin sa = 1; aop = 2'b10; end
      7:    begin rd = 1; rw = 1; end
      8:    begin sa = 1; aop = 2'b01; pcs = 2'b01; pcen = bne ? ~z : z; end
      10:   rw = 1;
      11:   begin pcs = 2'b10; pcen = 1; end
      default: ;
    endcase
    return {pcen, iord, mr, mw, irw, m2r, rd, rw, sa, il, sb, aop, pcs};
  endfunction

  // Called one time unit after a rising edge, with the DUT at the first FETCH cycle.
  task automatic run_instr(input logic [5:0] op, input bit z);
    int seq[$];
    bit bne = 0;
    bit ill = 0;
    int rem;
    rec_t r;
    for (int i = 0; i < L; i++) seq.push_back(0);
    seq.push_back(1);
    case (op)
      6'b100011: begin seq.push_back(2); for (int i = 0; i < L; i++) seq.push_back(3); seq.push_back(4); end
      6'b101011: begin seq.push_back(2); for (int i = 0; i < L; i++) seq.push_back(5); end
      6'b000000: begin seq.push_back(6); seq.push_back(7); end
      6'b000100: seq.push_back(8);
      6'b001000: begin seq.push_back(9); seq.push_back(10); end
      6'b000010: seq.push_back(11);
      6'b000101: begin
`ifdef MIPS_CTRL_BNE_EN
        seq.push_back(8);
        bne = 1;
`else
        ill = 1;
`endif
      end
      default: ill = 1;
    endcase
    for (int i = 0; i < seq.size(); i++) begin
      r.st  = 4'(seq[i]);
      r.o   = outs(seq[i], (seq[i] != 0) || (i == L - 1), z, bne, ill);
      r.ret = CW'(exp_ret);
      q.push_back(r);
    end
    if (!ill) exp_ret = (exp_ret + 1) % (1 << CW);
    Opcode = op;
    Zero   = z;
    repeat (L + 1) @(posedge CLK);
    #1 Opcode = 6'($urandom);
    rem = seq.size() - L - 1;
    repeat (rem) @(posedge CLK);
    if (rem > 0) #1;
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      if (q.size() == 0) begin
        chk("scoreboard_underflow", 32'(q.size()), 32'd1);
      end else begin
        mon_r = q.pop_front();
        chk("state", 32'(State), 32'(mon_r.st));
        chk("outputs", 32'({PCEn, IorD, MemRead, MemWrite, IRWrite, Mem2Reg, RegDst,
                            RegWrite, ALUSrcA, IllegalOp, ALUSrcB, ALUOp, PCSrc}), 32'(mon_r.o));
        chk("retired", 32'(Retired), 32'(mon_r.ret));
      end
    end
  end

  function automatic logic [5:0] rand_op();
    logic [5:0] tbl [8];
    tbl = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000101, 6'b111111};
    if ($urandom_range(0, 9) == 0) return 6'($urandom);
    return tbl[$urandom_range(0, 7)];
  endfunction

  initial begin
    int n;
    RST = 1'b1; Opcode = '0; Zero = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_state", 32'(State), 32'd0);
    chk("rst_retired", 32'(Retired), 32'd0);
    chk("rst_memread", 32'(MemRead), 32'd0);
    chk("rst_strobes", 32'({PCEn, IRWrite, MemWrite, RegWrite}), 32'd0);
    RST = 1'b0;
    mon_en = 1'b1;

    run_instr(6'b100011, 1'b0);
    run_instr(6'b101011, 1'b1);
    run_instr(6'b000100, 1'b1);
    run_instr(6'b000100, 1'b0);
    run_instr(6'b111111, 1'b0);
    run_instr(6'b000101, 1'b0);
    run_instr(6'b000101, 1'b1);
    run_instr(6'b001000, 1'b0);
    run_instr(6'b000010, 1'b0);
    for (int i = 0; i < 17; i++) run_instr(6'b000000, 1'($urandom));
    for (int i = 0; i < 60; i++) run_instr(rand_op(), 1'($urandom));
    chk("queue_drained", 32'(q.size()), 32'd0);
    mon_en = 1'b0;

    // Abort a store in the middle of its memory write.
    Opcode = 6'b101011;
    n = 0;
    while (State != 4'd5 && n < 50) begin
      @(posedge CLK); #1; n++;
    end
    chk("reach_memwr", 32'(n < 50), 32'd1);
    @(posedge CLK); #1;
    chk("memwr_active", 32'(MemWrite), 32'd1);
    chk("retired_before_rst", 32'(Retired), 32'(exp_ret));
    #2 RST = 1'b1;
    #1;
    chk("abort_memwrite", 32'(MemWrite), 32'd0);
    chk("abort_state", 32'(State), 32'd0);
    chk("abort_retired", 32'(Retired), 32'd0);
    chk("abort_memread", 32'(MemRead), 32'd0);
    @(posedge CLK); #1;
    chk("held_state", 32'(State), 32'd0);
    RST = 1'b0;
    exp_ret = 0;
    q.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 12; i++) run_instr(rand_op(), 1'($urandom));
    chk("queue_drained_end", 32'(q.size()), 32'd0);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
